// File: rtl/alu_muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq_pkg
// Purpose  : Opcode and FSM types plus opcode-decode helpers for the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
package alu_muldiv_seq_pkg;

  localparam logic [3:0] MULDIV_OPT_BASE = 4'h8;

  typedef enum logic [3:0] {
    OPT_MUL   = 4'h8,
    OPT_MULH  = 4'h9,
    OPT_MULHU = 4'hA,
    OPT_DIV   = 4'hB,
    OPT_DIVU  = 4'hC,
    OPT_REM   = 4'hD,
    OPT_REMU  = 4'hE
  } muldiv_opt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_e;

  // Opcode lies in the extended calc range 8..E
  function automatic logic fn_is_valid_opt(input logic [3:0] opt);
    return (opt >= MULDIV_OPT_BASE) && (opt <= OPT_REMU);
  endfunction

  // Divide family (quotient or remainder)
  function automatic logic fn_is_div(input logic [3:0] opt);
    return opt inside {OPT_DIV, OPT_DIVU, OPT_REM, OPT_REMU};
  endfunction

  // Ops whose operands are interpreted as two's complement
  function automatic logic fn_is_signed(input logic [3:0] opt);
    return opt inside {OPT_MULH, OPT_DIV, OPT_REM};
  endfunction

  // Divide ops returning the quotient (as opposed to the remainder)
  function automatic logic fn_is_quot(input logic [3:0] opt);
    return opt inside {OPT_DIV, OPT_DIVU};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq_core
// Purpose  : Per-cycle datapath: radix-2 shift-add multiply or restoring
//            divide, one bit per step, sharing one 2*XLEN accumulator.
//            Multiply: acc = {partial_hi, multiplier shifting out}.
//            Divide  : acc = {remainder, dividend shifting out / quotient in}.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic              r_is_div;

  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_trial;
  logic [XLEN:0]     w_diff;
  logic              w_borrow;
  logic [XLEN-1:0]   w_rem_nxt;

  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];

  // Multiply step: add the multiplicand when the current multiplier bit is set
  assign w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});

  // Divide step: shift the next dividend bit into the remainder, trial subtract.
  // The remainder is always below the divisor, so the shifted value fits in
  // XLEN+1 bits and bit XLEN of the difference is a clean borrow flag.
  assign w_trial   = {w_hi, w_lo[XLEN-1]};
  assign w_diff    = w_trial - {1'b0, r_b};
  assign w_borrow  = w_diff[XLEN];
  assign w_rem_nxt = w_borrow ? w_trial[XLEN-1:0] : w_diff[XLEN-1:0];

  // Load operands on start, advance one bit per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
    end else if (i_start) begin
      r_acc    <= {{XLEN{1'b0}}, i_a};
      r_b      <= i_b;
      r_is_div <= i_is_div;
    end else if (i_step) begin
      if (r_is_div) begin
        r_acc <= {w_rem_nxt, w_lo[XLEN-2:0], ~w_borrow};
      end else begin
        r_acc <= {w_sum, w_lo[XLEN-1:1]};
      end
    end
  end

  assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Multi-cycle MUL/DIV/REM execute unit behind valid/ready.
//            Owns the FSM, handshake, fast-path decode and sign fix-up;
//            the iterative datapath lives in alu_muldiv_seq_core.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [3:0]       i_in_opt,
  input  logic [XLEN-1:0]  i_in_a,
  input  logic [XLEN-1:0]  i_in_b,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_data,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_busy
);

  localparam int              CNT_W      = $clog2(XLEN);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  C_MIN      = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  C_ONES     = {XLEN{1'b1}};

  function automatic logic [XLEN-1:0] fn_neg(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  function automatic logic [XLEN-1:0] fn_abs(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? fn_neg(v) : v;
  endfunction

  muldiv_state_e     r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [3:0]        r_opt;
  logic              r_sa;
  logic              r_sb;
  logic              r_out_valid;
  logic [XLEN-1:0]   r_out_data;
  logic [TAG_W-1:0]  r_out_tag;

  logic              w_accept;
  logic              w_opt_ok;
  logic              w_is_div;
  logic              w_signed;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_fast;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_fast_data;
  logic [2*XLEN-1:0] w_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quot;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_data;

  // Flush blocks a same-cycle accept even when idle
  assign w_accept = i_in_valid & (r_state == ST_IDLE) & ~i_flush;

  assign w_opt_ok = fn_is_valid_opt(i_in_opt);
  assign w_is_div = w_opt_ok & fn_is_div(i_in_opt);
  assign w_signed = w_opt_ok & fn_is_signed(i_in_opt);
  assign w_b_zero = (i_in_b == '0);
  assign w_ovf    = w_signed & w_is_div & (i_in_a == C_MIN) & (i_in_b == C_ONES);
  assign w_fast   = ~w_opt_ok | (w_is_div & (w_b_zero | w_ovf));

  assign w_sa    = w_signed & i_in_a[XLEN-1];
  assign w_sb    = w_signed & i_in_b[XLEN-1];
  assign w_a_mag = w_signed ? fn_abs(i_in_a) : i_in_a;
  assign w_b_mag = w_signed ? fn_abs(i_in_b) : i_in_b;

  // Results that bypass the iterative path entirely
  always_comb begin
    w_fast_data = '0;
    if (w_is_div) begin
      if (w_b_zero) begin
        w_fast_data = fn_is_quot(i_in_opt) ? C_ONES : i_in_a;
      end else if (w_ovf) begin
        w_fast_data = fn_is_quot(i_in_opt) ? C_MIN : '0;
      end
    end
  end

  alu_muldiv_seq_core #(
    .XLEN (XLEN)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_accept & ~w_fast),
    .i_step   (r_state == ST_CALC),
    .i_is_div (w_is_div),
    .i_a      (w_a_mag),
    .i_b      (w_b_mag),
    .o_acc    (w_acc)
  );

  assign w_prod = (r_sa ^ r_sb) ? (~w_acc + (2*XLEN)'(1)) : w_acc;
  assign w_quot = w_acc[XLEN-1:0];
  assign w_rem  = w_acc[2*XLEN-1:XLEN];

  // Sign fix-up and half select of the raw magnitude result
  always_comb begin
    w_fix_data = '0;
    case (r_opt)
      OPT_MUL:            w_fix_data = w_prod[XLEN-1:0];
      OPT_MULH,
      OPT_MULHU:          w_fix_data = w_prod[2*XLEN-1:XLEN];
      OPT_DIV,
      OPT_DIVU:           w_fix_data = (r_sa ^ r_sb) ? fn_neg(w_quot) : w_quot;
      OPT_REM,
      OPT_REMU:           w_fix_data = r_sa ? fn_neg(w_rem) : w_rem;
      default:            w_fix_data = '0;
    endcase
  end

  // Control FSM with registered result and handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_opt       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_tag   <= '0;
    end else if (i_flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_opt     <= i_in_opt;
            r_sa      <= w_sa;
            r_sb      <= w_sb;
            r_out_tag <= i_in_tag;
            r_cnt     <= '0;
            if (w_fast) begin
              r_out_data  <= w_fast_data;
              r_out_valid <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == C_CNT_LAST) begin
            r_state <= ST_FIX;
          end
        end
        ST_FIX: begin
          r_out_data  <= w_fix_data;
          r_out_valid <= 1'b1;
          r_state     <= ST_DONE;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_tag   = r_out_tag;

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Iterative multiply/divide execute unit for the CPU core's extended calc opcodes (opt 8..E).
- The existing ALU is single-cycle and purely combinational; this block adds multi-cycle operations behind a valid/ready handshake.
- Operand width is parametrised.
- Sits beside the combinational calc path. Decode issues MUL/DIV ops here and stalls the pc until the result returns; the result carries a tag for rd write-back.

Parameters:
- XLEN, 32, operand/result width in bits (>=8, power of two)
- TAG_W, 5, width of the pass-through destination tag

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort of the in-flight op
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_opt  in  4  opcode: 8 MUL, 9 MULH (s×s), A MULHU, B DIV, C DIVU, D REM, E REMU; other values are invalid
- in_a  in  XLEN  operand a (rs1)
- in_b  in  XLEN  operand b (rs2)
- in_tag  in  TAG_W  destination tag
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag captured at accept
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0; out_data=0; out_tag=0; busy=0; in_ready=1; all internal registers 0.
- Accept condition: in_valid & in_ready on a rising edge; in_ready = (state==IDLE).
- At accept:
  - latch opt, tag and operand signs;
  - latch magnitudes |a| and |b| for signed ops, raw values for unsigned ops.
- States: IDLE -> CALC -> FIX -> DONE -> IDLE.
- CALC: exactly XLEN cycles; a counter runs 0..XLEN-1.
  - MUL*: radix-2 shift-add into a 2*XLEN product register.
  - DIV*/REM*: restoring division, one quotient bit per cycle.
- FIX: 1 cycle.
  - Apply sign: product negated if sign_a^sign_b; quotient negated if sign_a^sign_b; remainder takes sign_a.
  - Select low or high half for MUL/MULH/MULHU.
- Latency: accept at edge E0 -> out_valid high after edge E0+XLEN+1.
- Fast path (IDLE -> DONE at E0, out_valid after E0):
  - divide by zero: DIV/DIVU -> all ones; REM/REMU -> a.
  - signed overflow (a = MIN, b = -1): DIV -> MIN; REM -> 0.
  - invalid opt -> 0.
- DONE: out_valid=1; out_data and out_tag stable until out_valid & out_ready. Then -> IDLE, out_valid=0.
  - No new accept in the same cycle as the handoff; in_ready rises the following cycle.
- flush: forces IDLE from any state on the next edge and clears out_valid; the pending result is discarded.
  - flush has priority over out_ready and over accept.
  - flush while IDLE is a no-op and blocks any accept that cycle.
- Reset asserted mid-CALC: immediate return to the reset values; no partial result is visible afterwards.
- Arithmetic: all internal math unsigned on XLEN+1 bits; signs handled only in FIX. Results are truncated to XLEN.

Decomposition:
- Add to lib_cpu:
  - typedef enum for the muldiv opcodes (OPT_MUL..OPT_REMU);
  - typedef enum {IDLE, CALC, FIX, DONE} for the FSM state;
  - constant MULDIV_OPT_BASE = 4'h8.
- Pure helpers go in lib_alu as automatic functions: fn_abs, fn_neg, fn_is_div.
- One sub-module: muldiv_core.
  - Holds the per-cycle shift-add / restoring-subtract datapath.
  - Driven by start and step signals.
  - The top level owns the FSM, the handshake and the fast-path decode.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (XLEN=32) -> out_data=0xFFFFFFEB; out_valid exactly 33 cycles after accept.
- MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; REMU 100 % 7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5%0 -> 5, each out_valid 1 cycle after accept. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- out_ready held low 10 cycles in DONE -> out_data and out_tag=0x13 stable, in_ready=0. Then out_ready=1 -> IDLE, in_ready=1 one cycle later.
- flush at CALC cycle 5 -> IDLE next edge, no out_valid, and the next op completes correctly. rst_n pulsed low mid-CALC -> all outputs at reset values asynchronously.
